pid_mul_arbiter: RTL

//  Shares one signed 18x18 pipelined multiplier between up to four requesters,

---
 rtl/pid_mul_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pid_mul_arbiter.sv
// pid_mul_arbiter: round-robin arbiter sharing one signed AWxBW multiplier
// between up to four requesters. Each product comes back LAT cycles after
// its capture edge, tagged with the ID of the requester that won the grant.

// One pipeline stage carrying {valid, id, product}. The payload only loads
// when the incoming valid is set, so idle cycles leave the last product and
// ID in place.
module pid_mul_stage #(
  parameter int PW = 36
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  logic [1:0]    in_id,
  input  logic [PW-1:0] in_p,
  output logic          vld,
  output logic [1:0]    id,
  output logic [PW-1:0] p
);

  // Valid shifts every cycle; the payload loads only when the incoming beat is valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= 1'b0;
      id  <= '0;
      p   <= '0;
    end else begin
      vld <= in_vld;
      if (in_vld) begin
        id <= in_id;
        p  <= in_p;
      end
    end
  end

endmodule

module pid_mul_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 18,
  parameter int BW   = 18,
  parameter int LAT  = 2
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [NREQ-1:0]    Req,
  input  logic [NREQ*AW-1:0] A_in,
  input  logic [NREQ*BW-1:0] B_in,
  output logic [NREQ-1:0]    Gnt,
  output logic               Rsp_Valid,
  output logic [1:0]         Rsp_Id,
  output logic [AW+BW-1:0]   Rsp_P,
  output logic               Busy
);

  localparam int PW = AW + BW;

  logic [1:0]    ptr;
  logic [1:0]    ptr_nxt;
  logic [3:0]    req_pad;
  logic [2:0]    idx;
  logic [1:0]    win;
  logic          hit;
  logic [AW-1:0] a_sel;
  logic [BW-1:0] b_sel;
  logic [PW-1:0] prod;

  // Stage 0 is the arbiter output; stages 1..LAT are registered.
  logic [LAT:0]          vld_pipe;
  logic [LAT:0][1:0]     id_pipe;
  logic [LAT:0][PW-1:0]  p_pipe;

  // Round-robin search starting at ptr; requesters beyond NREQ read as idle.
  always_comb begin
    req_pad = '0;
    req_pad[NREQ-1:0] = Req;
    hit = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= 3'(NREQ)) idx = idx - 3'(NREQ);
      if (!hit && req_pad[idx[1:0]]) begin
        hit = 1'b1;
        win = idx[1:0];
      end
    end
  end

  // One-hot grant, suppressed during reset so a Req edge at reset is ignored.
  always_comb begin
    Gnt = '0;
    for (int i = 0; i < NREQ; i++) Gnt[i] = hit && Rst_n && (win == 2'(i));
  end

  // Priority moves to the requester just after the winner; with NREQ=1 it stays at 0.
  always_comb begin
    ptr_nxt = (win == 2'(NREQ - 1)) ? 2'd0 : win + 2'd1;
  end

  // Priority pointer register.
  always_ff @(posedge Clk) begin
    if (!Rst_n)   ptr <= '0;
    else if (hit) ptr <= ptr_nxt;
  end

  // Winner's operands, sign-extended to full width so the low PW bits of the
  // product are exact.
  always_comb begin
    a_sel = A_in[32'(win)*AW +: AW];
    b_sel = B_in[32'(win)*BW +: BW];
    prod  = {{BW{a_sel[AW-1]}}, a_sel} * {{AW{b_sel[BW-1]}}, b_sel};
  end

  assign vld_pipe[0] = hit && Rst_n;
  assign id_pipe[0]  = win;
  assign p_pipe[0]   = prod;

  for (genvar g = 1; g <= LAT; g++) begin : g_stage
    pid_mul_stage #(.PW(PW)) u_stage (
      .clk    (Clk),
      .rst_n  (Rst_n),
      .in_vld (vld_pipe[g-1]),
      .in_id  (id_pipe[g-1]),
      .in_p   (p_pipe[g-1]),
      .vld    (vld_pipe[g]),
      .id     (id_pipe[g]),
      .p      (p_pipe[g])
    );
  end

  assign Rsp_Valid = vld_pipe[LAT];
  assign Rsp_Id    = id_pipe[LAT];
  assign Rsp_P     = p_pipe[LAT];
  assign Busy      = |vld_pipe[LAT:1];

endmodule
